// File: rtl/hotspot_locator.sv
// Purpose: scan one GRID_W x GRID_H power map per frame, locate the strongest cell, map it to smoothed LCD pixel coordinates.
// Latency: pos_ena rises exactly 3 cycles after the last accepted sample of a frame (MAP, SMOOTH, OUT).
// Backpressure: none; samples are consumed whenever pwr_valid is high in SCAN, and ignored in every other state.
module hotspot_locator #(
  parameter int          GRID_W   = 16,
  parameter int          GRID_H   = 9,
  parameter int          PWR_W    = 32,
  parameter int          STEP_X   = 30,
  parameter int          STEP_Y   = 30,
  parameter int          OFS_X    = 15,
  parameter int          OFS_Y    = 15,
  parameter int unsigned THRESH   = 32'd1000,
  parameter int          ALPHA_SH = 1,
  parameter int          HOLD_X   = 238,
  parameter int          HOLD_Y   = 145
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pwr_valid,
  input  logic [PWR_W-1:0]        pwr_data,
  output logic signed [25:0]      pix_x_out,
  output logic signed [25:0]      pix_y_out,
  output logic                    pos_ena,
  output logic [PWR_W-1:0]        peak_pwr,
  output logic                    frame_err
);

  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [CW-1:0]        LAST_COL = CW'(GRID_W - 1);
  localparam logic [RW-1:0]        LAST_ROW = RW'(GRID_H - 1);
  localparam logic signed [25:0]   STEP_X_C = 26'(STEP_X);
  localparam logic signed [25:0]   STEP_Y_C = 26'(STEP_Y);
  localparam logic signed [25:0]   OFS_X_C  = 26'(OFS_X);
  localparam logic signed [25:0]   OFS_Y_C  = 26'(OFS_Y);
  localparam logic signed [25:0]   HOLD_X_C = 26'(HOLD_X);
  localparam logic signed [25:0]   HOLD_Y_C = 26'(HOLD_Y);
  localparam logic [PWR_W-1:0]     THRESH_C = PWR_W'(THRESH);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_MAP, S_SMOOTH, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d, bcol_q, bcol_d;
  logic [RW-1:0]          row_q, row_d, brow_q, brow_d;
  logic [PWR_W-1:0]       max_q, max_d, peak_q, peak_d;
  logic signed [25:0]     raw_x_q, raw_x_d, raw_y_q, raw_y_d;
  logic signed [25:0]     sm_x_q, sm_x_d, sm_y_q, sm_y_d;
  logic signed [25:0]     pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                   have_pos_q, have_pos_d;
  logic                   pos_ena_q, pos_ena_d;
  logic                   frame_err_q, frame_err_d;

  // A frame_start in IDLE or SCAN (re)opens a frame; a coincident sample becomes cell 0.
  logic                   start, acc;
  logic [CW-1:0]          cur_col;
  logic [RW-1:0]          cur_row;
  logic [PWR_W-1:0]       cur_max;
  assign start   = frame_start && (state_q == S_IDLE || state_q == S_SCAN);
  assign acc     = pwr_valid && (start || state_q == S_SCAN);
  assign cur_col = start ? '0 : col_q;
  assign cur_row = start ? '0 : row_q;
  assign cur_max = start ? '0 : max_q;

  // First-order smoothing candidate; the very first detection loads raw coordinates directly.
  logic signed [25:0]     dx, dy, blend_x, blend_y, nx, ny;
  assign dx      = raw_x_q - sm_x_q;
  assign dy      = raw_y_q - sm_y_q;
  assign blend_x = sm_x_q + (dx >>> ALPHA_SH);
  assign blend_y = sm_y_q + (dy >>> ALPHA_SH);
  assign nx      = have_pos_q ? blend_x : raw_x_q;
  assign ny      = have_pos_q ? blend_y : raw_y_q;

  // Next-state, scan bookkeeping and result computation.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    max_d       = max_q;
    bcol_d      = bcol_q;
    brow_d      = brow_q;
    raw_x_d     = raw_x_q;
    raw_y_d     = raw_y_q;
    sm_x_d      = sm_x_q;
    sm_y_d      = sm_y_q;
    have_pos_d  = have_pos_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    peak_d      = peak_q;
    pos_ena_d   = 1'b0;
    frame_err_d = 1'b0;

    if (start) begin
      state_d     = S_SCAN;
      col_d       = '0;
      row_d       = '0;
      max_d       = '0;
      bcol_d      = '0;
      brow_d      = '0;
      frame_err_d = (state_q == S_SCAN);
    end

    case (state_q)
      S_MAP: begin
        raw_x_d = $signed(26'(bcol_q)) * STEP_X_C + OFS_X_C;
        raw_y_d = $signed(26'(brow_q)) * STEP_Y_C + OFS_Y_C;
        state_d = S_SMOOTH;
      end
      S_SMOOTH: begin
        peak_d    = max_q;
        pos_ena_d = 1'b1;
        state_d   = S_OUT;
        if (max_q < THRESH_C) begin
          pix_x_d = HOLD_X_C;
          pix_y_d = HOLD_Y_C;
        end else begin
          sm_x_d     = nx;
          sm_y_d     = ny;
          have_pos_d = 1'b1;
          pix_x_d    = (nx == HOLD_X_C && ny == HOLD_Y_C) ? HOLD_X_C + 26'sd1 : nx;
          pix_y_d    = ny;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: ;
    endcase

    // Strictly-greater compare keeps the earliest cell on ties.
    if (acc) begin
      if (pwr_data > cur_max) begin
        max_d  = pwr_data;
        bcol_d = cur_col;
        brow_d = cur_row;
      end
      if (cur_col == LAST_COL) begin
        col_d = '0;
        if (cur_row == LAST_ROW) begin
          row_d   = '0;
          state_d = S_MAP;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      max_q       <= '0;
      bcol_q      <= '0;
      brow_q      <= '0;
      raw_x_q     <= '0;
      raw_y_q     <= '0;
      sm_x_q      <= '0;
      sm_y_q      <= '0;
      have_pos_q  <= 1'b0;
      pix_x_q     <= HOLD_X_C;
      pix_y_q     <= HOLD_Y_C;
      peak_q      <= '0;
      pos_ena_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      max_q       <= max_d;
      bcol_q      <= bcol_d;
      brow_q      <= brow_d;
      raw_x_q     <= raw_x_d;
      raw_y_q     <= raw_y_d;
      sm_x_q      <= sm_x_d;
      sm_y_q      <= sm_y_d;
      have_pos_q  <= have_pos_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      peak_q      <= peak_d;
      pos_ena_q   <= pos_ena_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pix_x_out = pix_x_q;
  assign pix_y_out = pix_y_q;
  assign pos_ena   = pos_ena_q;
  assign peak_pwr  = peak_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hotspot_locator.sv
// Bench for hotspot_locator: directed frames plus randomized frames against a reference model.
// Inputs driven and outputs sampled on the falling edge of clk_pix.
// Reference model works on whole-frame arrays with plain integer arithmetic.
module tb_hotspot_locator;

  logic               clk_pix = 1'b0;
  logic               rst_n;
  logic               frame_start;
  logic               pwr_valid;
  logic [31:0]        pwr_data;
  logic signed [25:0] pix_x_out;
  logic signed [25:0] pix_y_out;
  logic               pos_ena;
  logic [31:0]        peak_pwr;
  logic               frame_err;

  hotspot_locator dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pwr_valid   (pwr_valid),
    .pwr_data    (pwr_data),
    .pix_x_out   (pix_x_out),
    .pix_y_out   (pix_y_out),
    .pos_ena     (pos_ena),
    .peak_pwr    (peak_pwr),
    .frame_err   (frame_err)
  );

  always #5 clk_pix = ~clk_pix;

  int n_chk  = 0;
  int n_fail = 0;
  int ena_cnt = 0;
  int err_cnt = 0;

  // Pulse counters, sampled on the rising edge so they never race the falling-edge checks.
  always @(posedge clk_pix) begin
    if (pos_ena)   ena_cnt <= ena_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: smoothed position and whether one exists.
  logic [31:0] fr [144];
  int          m_have = 0;
  int          m_sx   = 0;
  int          m_sy   = 0;

  task automatic model_frame(output int ex, output int ey, output logic [31:0] epk);
    logic [31:0] mx;
    int          bi;
    int          rx, ry;
    mx = 0;
    bi = 0;
    for (int i = 0; i < 144; i++) begin
      if (fr[i] > mx) begin
        mx = fr[i];
        bi = i;
      end
    end
    rx  = (bi % 16) * 30 + 15;
    ry  = (bi / 16) * 30 + 15;
    epk = mx;
    if (mx < 32'd1000) begin
      ex = 238;
      ey = 145;
    end else begin
      if (m_have == 0) begin
        m_sx   = rx;
        m_sy   = ry;
        m_have = 1;
      end else begin
        m_sx = m_sx + ((rx - m_sx) >>> 1);
        m_sy = m_sy + ((ry - m_sy) >>> 1);
      end
      ex = m_sx;
      ey = m_sy;
      if (ex == 238 && ey == 145) ex = 239;
    end
  endtask

  task automatic gen_frame(input int kind);
    int a, b;
    for (int i = 0; i < 144; i++) begin
      case (kind)
        0:       fr[i] = $urandom_range(0, 3000);
        1:       fr[i] = $urandom_range(0, 999);
        default: fr[i] = 32'd0;
      endcase
    end
    if (kind >= 2) begin
      a = $urandom_range(0, 143);
      b = $urandom_range(0, 143);
      fr[a] = 32'd8000 + (kind == 2 ? 32'd0 : 32'd1);
      fr[b] = 32'd8000;
    end
  endtask

  // Drive samples [from, to); gap 0 = contiguous, 1 = one idle cycle between samples, 2 = random gaps.
  task automatic send(input int from, input int to, input int gap);
    int n;
    for (int i = from; i < to; i++) begin
      @(negedge clk_pix);
      frame_start = 1'b0;
      pwr_valid   = 1'b1;
      pwr_data    = fr[i];
      if (i < to - 1) begin
        n = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
        repeat (n) begin
          @(negedge clk_pix);
          pwr_valid = 1'b0;
          pwr_data  = $urandom;
        end
      end
    end
  endtask

  // Observe the four cycles after the last sample; junk adds ignored samples and a frame_start in MAP.
  task automatic tail(input string tag, input bit junk);
    int          ex, ey;
    logic [31:0] epk;
    logic [3:0]  pat;
    logic [25:0] gx, gy;
    logic [31:0] gp;
    model_frame(ex, ey, epk);
    gx = '0; gy = '0; gp = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pix);
      frame_start = junk && (k == 0);
      pwr_valid   = junk;
      pwr_data    = 32'hFFFF_FFF0;
      pat[k]      = pos_ena;
      if (k == 2) begin
        gx = pix_x_out;
        gy = pix_y_out;
        gp = peak_pwr;
      end
    end
    frame_start = 1'b0;
    pwr_valid   = 1'b0;
    chk({tag, "_ena_timing"}, 64'(pat), 64'(4'b0100));
    chk({tag, "_x"}, 64'(gx), 64'(26'(ex)));
    chk({tag, "_y"}, 64'(gy), 64'(26'(ey)));
    chk({tag, "_peak"}, 64'(gp), 64'(epk));
    chk({tag, "_x_hold"}, 64'(26'(pix_x_out)), 64'(26'(ex)));
  endtask

  task automatic run_frame(input string tag, input int gap, input bit coinc, input bit junk);
    repeat (2) begin
      @(negedge clk_pix);
      frame_start = 1'b0;
      pwr_valid   = junk;
      pwr_data    = 32'hFFFF_FFF0;
    end
    @(negedge clk_pix);
    frame_start = 1'b1;
    pwr_valid   = coinc;
    pwr_data    = fr[0];
    send(coinc ? 1 : 0, 144, gap);
    tail(tag, junk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, f0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pwr_valid   = 1'b0;
    pwr_data    = '0;
    repeat (3) @(negedge clk_pix);
    chk("rst_x",    64'(26'(pix_x_out)), 64'(26'd238));
    chk("rst_y",    64'(26'(pix_y_out)), 64'(26'd145));
    chk("rst_ena",  64'(pos_ena),   64'(0));
    chk("rst_peak", 64'(peak_pwr),  64'(0));
    chk("rst_err",  64'(frame_err), 64'(0));
    rst_n = 1'b1;

    // Single peak at col 4, row 3.
    for (int i = 0; i < 144; i++) fr[i] = 32'd0;
    fr[52] = 32'd5000;
    run_frame("A", 0, 0, 0);
    chk("A_lit_x", 64'(26'(pix_x_out)), 64'(26'd135));
    chk("A_lit_y", 64'(26'(pix_y_out)), 64'(26'd105));

    // Peak at col 12, row 3: smoothed halfway.
    for (int i = 0; i < 144; i++) fr[i] = 32'd0;
    fr[60] = 32'd5000;
    run_frame("B", 0, 0, 0);
    chk("B_lit_x", 64'(26'(pix_x_out)), 64'(26'd255));

    // Below threshold: sentinel, state kept.
    for (int i = 0; i < 144; i++) fr[i] = 32'd500;
    run_frame("C", 0, 0, 0);
    chk("C_lit_x", 64'(26'(pix_x_out)), 64'(26'd238));
    chk("C_lit_y", 64'(26'(pix_y_out)), 64'(26'd145));

    // Smoothing resumes from the previous state (255), not the sentinel.
    for (int i = 0; i < 144; i++) fr[i] = 32'd0;
    fr[52] = 32'd5000;
    run_frame("D", 0, 0, 0);
    chk("D_lit_x", 64'(26'(pix_x_out)), 64'(26'd195));

    // Short frame aborted after 60 samples; restart sample coincident with frame_start.
    gen_frame(0);
    fr[10] = 32'h7FFF_FFFF;
    e0 = ena_cnt;
    f0 = err_cnt;
    @(negedge clk_pix);
    frame_start = 1'b1;
    pwr_valid   = 1'b0;
    send(0, 60, 0);
    gen_frame(0);
    @(negedge clk_pix);
    frame_start = 1'b1;
    pwr_valid   = 1'b1;
    pwr_data    = fr[0];
    @(negedge clk_pix);
    chk("abort_err_pulse", 64'(frame_err), 64'(1));
    chk("abort_no_ena",    64'(ena_cnt - e0), 64'(0));
    frame_start = 1'b0;
    pwr_data    = fr[1];
    @(negedge clk_pix);
    chk("abort_err_clear", 64'(frame_err), 64'(0));
    pwr_data = fr[2];
    send(3, 144, 0);
    tail("abort", 0);
    chk("abort_ena_count", 64'(ena_cnt - e0), 64'(1));
    chk("abort_err_count", 64'(err_cnt - f0), 64'(1));

    // Reset mid-frame at sample 100 with pwr_valid held high.
    gen_frame(0);
    @(negedge clk_pix);
    frame_start = 1'b1;
    pwr_valid   = 1'b0;
    send(0, 100, 0);
    e0 = ena_cnt;
    @(negedge clk_pix);
    rst_n     = 1'b0;
    pwr_valid = 1'b1;
    pwr_data  = fr[100];
    #1;
    chk("mrst_x_async", 64'(26'(pix_x_out)), 64'(26'd238));
    chk("mrst_y_async", 64'(26'(pix_y_out)), 64'(26'd145));
    repeat (3) @(negedge clk_pix);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk_pix);
      pwr_data = $urandom;
    end
    pwr_valid = 1'b0;
    chk("mrst_no_ena", 64'(ena_cnt - e0), 64'(0));
    chk("mrst_peak",   64'(peak_pwr), 64'(0));
    chk("mrst_y",      64'(26'(pix_y_out)), 64'(26'd145));
    m_have = 0;
    m_sx   = 0;
    m_sy   = 0;

    // Equal peaks: earliest cell wins, loaded unsmoothed after reset.
    for (int i = 0; i < 144; i++) fr[i] = 32'd0;
    fr[2]  = 32'd7000;
    fr[40] = 32'd7000;
    run_frame("tie", 0, 0, 0);
    chk("tie_lit_x", 64'(26'(pix_x_out)), 64'(26'd75));
    chk("tie_lit_y", 64'(26'(pix_y_out)), 64'(26'd15));

    // pwr_valid toggling every cycle.
    gen_frame(0);
    run_frame("toggle", 1, 0, 0);

    // Randomized frames: mixed content, gaps, coincident starts and ignored junk.
    for (int r = 0; r < 12; r++) begin
      gen_frame(r % 4);
      run_frame($sformatf("rnd%0d", r), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    chk("err_total", 64'(err_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hotspot_locator.md
Name: hotspot_locator

Overview:
- Producer side of the hotspot position interface.
- Scans one beamforming power map per frame, raster order, GRID_W x GRID_H cells, and finds the strongest cell.
- Maps that cell to LCD pixel coordinates and applies first-order smoothing.
- Drives signed 26-bit pixel coordinates plus a one-cycle enable to the hotspot overlay stage.
- Emits the hold sentinel (HOLD_X, HOLD_Y) when no source exceeds threshold; the overlay treats this as "keep last position".

Parameters:
- GRID_W, 16, grid columns.
- GRID_H, 9, grid rows.
- PWR_W, 32, power sample width (unsigned).
- STEP_X, 30, pixels per grid column.
- STEP_Y, 30, pixels per grid row.
- OFS_X, 15, pixel x of column 0 centre.
- OFS_Y, 15, pixel y of row 0 centre.
- THRESH, 32'd1000, minimum peak power for a valid detection.
- ALPHA_SH, 1, smoothing shift (0 = no smoothing).
- HOLD_X, 238, sentinel x.
- HOLD_Y, 145, sentinel y.

Ports:
- clk_pix  input  1  pixel-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse; the coincident or next accepted sample is cell 0.
- pwr_valid  input  1  power sample valid.
- pwr_data  input  PWR_W  unsigned power of current cell.
- pix_x_out  output  26 signed  hotspot centre x.
- pix_y_out  output  26 signed  hotspot centre y.
- pos_ena  output  1  one-cycle pulse, new coordinates valid.
- peak_pwr  output  PWR_W  peak power of last completed frame.
- frame_err  output  1  one-cycle pulse, frame aborted.

Behaviour:
- Reset values (asynchronous, active-low):
  - pix_x_out=HOLD_X, pix_y_out=HOLD_Y.
  - pos_ena=0, peak_pwr=0, frame_err=0.
  - FSM=IDLE, have_pos=0, all counters and registers 0.
- Clock and reset: single clock. Reset is asynchronous and active-low; clock port clk_pix, reset port rst_n.
- FSM states: IDLE, SCAN, MAP, SMOOTH, OUT.
  - IDLE -> SCAN on frame_start. Column, row and cell counters clear; max register clears to 0.
  - SCAN:
    - Each cycle with pwr_valid=1 accepts one sample.
    - The max register updates only when pwr_data > max (strictly greater), so ties keep the earliest cell in raster order.
    - Best column and row are latched together with max.
    - The column counter wraps at GRID_W-1 and increments the row counter.
    - When the sample for cell GRID_W*GRID_H-1 is accepted (cycle T), go to MAP.
  - MAP (T+1): raw_x = best_col*STEP_X+OFS_X, raw_y = best_row*STEP_Y+OFS_Y, computed as 26-bit signed.
  - SMOOTH (T+2):
    - If max < THRESH: result = (HOLD_X, HOLD_Y); smoothing state and have_pos unchanged.
    - Else if have_pos=0: state = raw; have_pos set.
    - Else: state = state + ((raw - state) >>> ALPHA_SH), arithmetic shift, truncation toward -inf.
    - If a valid (above-threshold) result equals (HOLD_X, HOLD_Y) exactly, output x = HOLD_X+1.
  - OUT (T+3):
    - pos_ena=1 for exactly one cycle.
    - pix_x_out, pix_y_out and peak_pwr update this cycle and then hold until the next OUT.
    - Return to IDLE.
- frame_start during SCAN (short frame):
  - Abort the current frame; frame_err pulses on the next cycle; no pos_ena.
  - Restart SCAN at cell 0. If pwr_valid is coincident, that sample is cell 0 of the new frame.
- Samples arriving while in IDLE, MAP, SMOOTH or OUT are ignored.
- frame_start during MAP, SMOOTH or OUT is ignored.
- pwr_valid gaps inside SCAN are allowed; counters hold.
- Latency: fixed 3 cycles from the last accepted sample to pos_ena.
- Reset asserted mid-frame: everything returns to reset values immediately; no pos_ena is produced for the partial frame.

Test Plan:
- Reset, then frame of 144 samples with all 0 except cell 52 (col 4, row 3) = 5000 -> pos_ena 3 cycles after last sample; pix_x_out=135, pix_y_out=105, peak_pwr=5000.
- Second frame, peak at col 12, row 3 = 5000, ALPHA_SH=1 -> x = 135 + (375-135)>>>1 = 255, y=105.
- Equal peaks 7000 at cells 2 and 40 -> first detection gives x=75, y=15 (earliest cell wins).
- All cells 500 (below THRESH) after a valid position -> outputs (238,145) with pos_ena. Next frame peak at col 4, row 3 -> smooths from the previous state, not from the sentinel.
- frame_start after 60 samples -> frame_err pulse, no pos_ena. A following full frame produces a correct result.
- rst_n low at sample 100 with pwr_valid held high -> outputs (238,145), pos_ena never asserted. After release, a fresh full frame loads raw coordinates unsmoothed (have_pos cleared).
- pwr_valid toggling 1/0 every cycle across a full frame -> same result as the contiguous frame, pos_ena 3 cycles after the 144th accepted sample.
